// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiply/divide unit between NumReq requesters.
// Captures the winner's operation, sequences the unit handshake and holds the result for its owner.
module ibex_multdiv_arbiter #(
  parameter int unsigned  NumReq = 2,
  localparam int unsigned OwnW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][1:0]   req_operator_i,
  input  logic [NumReq-1:0][1:0]   req_signed_mode_i,
  input  logic [NumReq-1:0][31:0]  req_op_a_i,
  input  logic [NumReq-1:0][31:0]  req_op_b_i,
  input  logic [NumReq-1:0]        req_flush_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic [31:0]              rsp_result_o,
  output logic                     md_mult_en_o,
  output logic                     md_div_en_o,
  output logic                     md_mult_sel_o,
  output logic                     md_div_sel_o,
  output logic [1:0]               md_operator_o,
  output logic [1:0]               md_signed_mode_o,
  output logic [31:0]              md_op_a_o,
  output logic [31:0]              md_op_b_o,
  output logic                     md_ready_id_o,
  input  logic                     md_valid_i,
  input  logic [31:0]              md_result_i,
  output logic                     busy_o,
  output logic [OwnW-1:0]          owner_o
);

  localparam logic [1:0] MD_OP_MULL = 2'd0;
  localparam logic [1:0] MD_OP_MULH = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;
  localparam logic [1:0] MD_OP_REM  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  state_e          state;
  md_req_t         cur;
  logic [31:0]     result_q;
  logic [OwnW-1:0] rr_ptr, owner, gnt_idx, cand;
  logic            gnt_vld, discard, flush_own;
  logic            win_mult, win_div;

  assign flush_own = req_flush_i[owner];

  // First valid, non-flushing requester at or after rr_ptr; only IDLE may grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand = OwnW'((int'(rr_ptr) + k) % int'(NumReq));
      if (!gnt_vld && req_valid_i[cand] && !req_flush_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (state != IDLE) gnt_vld = 1'b0;
  end

  assign win_mult = req_operator_i[gnt_idx] inside {MD_OP_MULL, MD_OP_MULH};
  assign win_div  = req_operator_i[gnt_idx] inside {MD_OP_DIV, MD_OP_REM};

  for (genvar i = 0; i < NumReq; i++) begin : g_lane
    assign req_ready_o[i] = gnt_vld && (gnt_idx == OwnW'(i));
    // Owner's flush masks the response in the same cycle it is raised.
    assign rsp_valid_o[i] = (state == RESP) && !flush_own && (owner == OwnW'(i));
  end

  assign rsp_result_o     = (state == RESP) ? result_q : '0;
  assign md_operator_o    = cur.op;
  assign md_signed_mode_o = cur.sm;
  assign md_op_a_o        = cur.a;
  assign md_op_b_o        = cur.b;
  assign busy_o           = (state != IDLE);
  assign owner_o          = owner;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cur           <= '0;
      result_q      <= '0;
      rr_ptr        <= '0;
      owner         <= '0;
      discard       <= 1'b0;
      md_mult_en_o  <= 1'b0;
      md_div_en_o   <= 1'b0;
      md_mult_sel_o <= 1'b0;
      md_div_sel_o  <= 1'b0;
      md_ready_id_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          cur           <= '{op: req_operator_i[gnt_idx], sm: req_signed_mode_i[gnt_idx],
                             a: req_op_a_i[gnt_idx], b: req_op_b_i[gnt_idx]};
          owner         <= gnt_idx;
          discard       <= 1'b0;
          rr_ptr        <= OwnW'((int'(gnt_idx) + 1) % int'(NumReq));
          md_mult_en_o  <= win_mult;
          md_mult_sel_o <= win_mult;
          md_div_en_o   <= win_div;
          md_div_sel_o  <= win_div;
          md_ready_id_o <= 1'b1;
          state         <= BUSY;
        end
        BUSY: begin
          // The unit cannot be aborted, so a flush only marks the result for dropping.
          if (flush_own) discard <= 1'b1;
          if (md_valid_i) begin
            result_q      <= md_result_i;
            md_mult_en_o  <= 1'b0;
            md_mult_sel_o <= 1'b0;
            md_div_en_o   <= 1'b0;
            md_div_sel_o  <= 1'b0;
            md_ready_id_o <= 1'b0;
            state         <= (discard || flush_own) ? IDLE : RESP;
          end
        end
        RESP: if (flush_own || rsp_ready_i[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_valid_o));
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_en_busy:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (md_mult_en_o || md_div_en_o) |-> (state == BUSY));
  a_mdv_busy:   assert property (@(posedge clk_i) disable iff (!rst_ni) md_valid_i |-> (state == BUSY));

endmodule
